// File: rtl/fifo_axis_reader.sv
// ---------------------------------------------------------------------------------------------
// fifo_axis_reader
//   Drains a synchronous FIFO read port and presents the words as an AXI4-Stream master.
//   The FIFO has a 1-cycle registered read latency. A 2-entry output buffer absorbs it, so
//   the stream can sustain one beat per cycle while the FIFO is non-empty and TREADY is high.
//   TLAST marks every BURST_LEN-th accepted beat. BURST_DONE pulses for one cycle after the
//   TLAST beat is accepted.
//
// Ports
//   i_aclk            clock, all logic on the rising edge
//   i_areset_n        synchronous active-low reset
//   i_enable          1 = new FIFO reads may be issued
//   i_fifo_empty      FIFO empty flag
//   i_fifo_data       FIFO read data, valid the cycle after an accepted read
//   o_fifo_rd_en      FIFO read strobe (combinational)
//   o_m_axis_tvalid   stream beat valid
//   i_m_axis_tready   downstream ready
//   o_m_axis_tdata    stream data (buffer head)
//   o_m_axis_tlast    last beat of a packet
//   o_burst_done      1-cycle pulse after the TLAST beat is accepted
// ---------------------------------------------------------------------------------------------
module fifo_axis_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                  i_aclk,
    input  logic                  i_areset_n,
    input  logic                  i_enable,
    input  logic                  i_fifo_empty,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    output logic                  o_fifo_rd_en,
    output logic                  o_m_axis_tvalid,
    input  logic                  i_m_axis_tready,
    output logic [DATA_WIDTH-1:0] o_m_axis_tdata,
    output logic                  o_m_axis_tlast,
    output logic                  o_burst_done
);

    localparam int unsigned      CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    // r_buf0 is always the head; r_buf1 holds the second word when r_occ == 2
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;
    logic [1:0]            r_occ;
    logic                  r_inflight;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_burst_done;

    logic                  w_pop;
    logic                  w_tlast;
    logic [2:0]            w_level;
    logic [1:0]            w_wr_idx;
    logic [1:0]            w_occ_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [DATA_WIDTH-1:0] w_buf0_nxt;
    logic [DATA_WIDTH-1:0] w_buf1_nxt;

    always_comb begin
        o_m_axis_tvalid = (r_occ != 2'd0);
        w_pop           = o_m_axis_tvalid && i_m_axis_tready;
        w_tlast         = o_m_axis_tvalid && (r_cnt == LAST_CNT);

        // Words that will still occupy the buffer after this cycle's pop. Issuing a read
        // only while this is <= 1 guarantees the 2-entry buffer cannot overflow.
        w_level      = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
        o_fifo_rd_en = i_areset_n && i_enable && !i_fifo_empty && (w_level <= 3'd1);

        // A returning word lands behind whatever survives this cycle's pop
        w_wr_idx  = r_occ - {1'b0, w_pop};
        w_occ_nxt = w_wr_idx + {1'b0, r_inflight};

        w_buf0_nxt = r_buf0;
        w_buf1_nxt = r_buf1;
        if (w_pop) begin
            w_buf0_nxt = r_buf1;
        end
        if (r_inflight) begin
            if (w_wr_idx == 2'd0) begin
                w_buf0_nxt = i_fifo_data;
            end else begin
                w_buf1_nxt = i_fifo_data;
            end
        end

        w_cnt_nxt = r_cnt;
        if (w_pop) begin
            w_cnt_nxt = (r_cnt == LAST_CNT) ? '0 : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_aclk) begin
        if (!i_areset_n) begin
            r_buf0       <= '0;
            r_buf1       <= '0;
            r_occ        <= 2'd0;
            r_inflight   <= 1'b0;
            r_cnt        <= '0;
            r_burst_done <= 1'b0;
        end else begin
            r_buf0       <= w_buf0_nxt;
            r_buf1       <= w_buf1_nxt;
            r_occ        <= w_occ_nxt;
            r_inflight   <= o_fifo_rd_en;
            r_cnt        <= w_cnt_nxt;
            r_burst_done <= w_pop && w_tlast;
        end
    end

    assign o_m_axis_tdata = r_buf0;
    assign o_m_axis_tlast = w_tlast;
    assign o_burst_done   = r_burst_done;

endmodule
